// File: rtl/gs_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage GS core.
// Produces the ID-stage operand forwarding selects and the IF/ID/EX halt and flush
// controls for load-use hazards, LSU waits and EX-resolved PC redirects. It also
// keeps saturating performance counters for stall cycles and accepted redirects.
module gs_pipeline_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             ex_valid_i,
  input  logic             ex_RegWrite_i,
  input  logic             ex_MemRead_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic [1:0]       ex_PCSrc_i,
  input  logic             wb_valid_i,
  input  logic             wb_RegWrite_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             lsu_busy_i,
  input  logic             perf_clr_i,
  output logic [1:0]       rs1_forward_sel_o,
  output logic [1:0]       rs2_forward_sel_o,
  output logic             halt_if_o,
  output logic             halt_id_o,
  output logic             halt_ex_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             pc_redirect_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {RUN, LSTALL, MWAIT, FLUSH} state_t;

  localparam logic [1:0] REG_NO_FORWARD = 2'd0;
  localparam logic [1:0] REG_EX_FORWARD = 2'd1;
  localparam logic [1:0] REG_WB_FORWARD = 2'd2;

  // Extra cycles spent in LSTALL / FLUSH after the cycle that detected the event.
  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;

  logic ex_fwd_ok, wb_fwd_ok, lu_hit, rd_hit;

  // EX priority over WB; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       ex_ok,
                                         input logic [4:0] ex_rd,
                                         input logic       wb_ok,
                                         input logic [4:0] wb_rd);
    if (ex_ok && ex_rd == rs)      return REG_EX_FORWARD;
    else if (wb_ok && wb_rd == rs) return REG_WB_FORWARD;
    else                           return REG_NO_FORWARD;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ex_fwd_ok = ex_valid_i && ex_RegWrite_i && !ex_MemRead_i && (ex_rd_addr_i != 5'd0);
  assign wb_fwd_ok = wb_valid_i && wb_RegWrite_i && (wb_rd_addr_i != 5'd0);
  assign lu_hit    = id_valid_i && ex_valid_i && ex_MemRead_i && (ex_rd_addr_i != 5'd0) &&
                     ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
  assign rd_hit    = ex_valid_i && (ex_PCSrc_i != 2'd0);

  // Next-state and Mealy controls; reset forces every output low in the same cycle.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    rs1_forward_sel_o = REG_NO_FORWARD;
    rs2_forward_sel_o = REG_NO_FORWARD;
    halt_if_o         = 1'b0;
    halt_id_o         = 1'b0;
    halt_ex_o         = 1'b0;
    flush_id_o        = 1'b0;
    flush_ex_o        = 1'b0;
    pc_redirect_o     = 1'b0;
    if (rst) begin
      state_nxt = RUN;
      cnt_nxt   = 3'd0;
    end else begin
      rs1_forward_sel_o = fwd_sel(id_rs1_addr_i, ex_fwd_ok, ex_rd_addr_i, wb_fwd_ok, wb_rd_addr_i);
      rs2_forward_sel_o = fwd_sel(id_rs2_addr_i, ex_fwd_ok, ex_rd_addr_i, wb_fwd_ok, wb_rd_addr_i);
      case (state)
        // MWAIT holds while the LSU is busy and otherwise behaves exactly like RUN,
        // so a redirect waiting in EX is accepted in the release cycle.
        RUN, MWAIT: begin
          if (lsu_busy_i) begin
            halt_if_o = 1'b1;
            halt_id_o = 1'b1;
            halt_ex_o = 1'b1;
            state_nxt = MWAIT;
          end else if (rd_hit) begin
            pc_redirect_o = 1'b1;
            flush_id_o    = 1'b1;
            flush_ex_o    = 1'b1;
            state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_nxt       = FLUSH_RELOAD;
          end else if (lu_hit) begin
            halt_if_o  = 1'b1;
            halt_id_o  = 1'b1;
            flush_ex_o = 1'b1;
            state_nxt  = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
            cnt_nxt    = LOAD_RELOAD;
          end else begin
            state_nxt = RUN;
          end
        end
        // A busy LSU preempts the load stall and discards the remaining count.
        LSTALL: begin
          if (lsu_busy_i) begin
            halt_if_o = 1'b1;
            halt_id_o = 1'b1;
            halt_ex_o = 1'b1;
            state_nxt = MWAIT;
            cnt_nxt   = 3'd0;
          end else begin
            halt_if_o  = 1'b1;
            halt_id_o  = 1'b1;
            flush_ex_o = 1'b1;
            if (cnt <= 3'd1) state_nxt = RUN;
            cnt_nxt = cnt - 3'd1;
          end
        end
        // EX is being squashed, so any redirect it shows is not genuine.
        FLUSH: begin
          flush_id_o = 1'b1;
          flush_ex_o = 1'b1;
          if (cnt <= 3'd1) state_nxt = RUN;
          cnt_nxt = cnt - 3'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM state and remaining-cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating performance counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr_i) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (halt_id_o)     stall_cnt_q    <= sat_inc(stall_cnt_q);
      if (pc_redirect_o) redirect_cnt_q <= sat_inc(redirect_cnt_q);
    end
  end

  assign stall_cnt_o    = rst ? '0 : stall_cnt_q;
  assign redirect_cnt_o = rst ? '0 : redirect_cnt_q;

endmodule

// File: tb/tb_gs_pipeline_ctrl.sv
// Bench for gs_pipeline_ctrl: two instances with different parameters share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_gs_pipeline_ctrl;

  localparam int LSC  [2] = '{2, 3};
  localparam int FLC  [2] = '{2, 4};
  localparam int CMAX [2] = '{15, 65535};

  logic clk = 1'b0;
  logic rst, id_valid_i, ex_valid_i, ex_RegWrite_i, ex_MemRead_i;
  logic wb_valid_i, wb_RegWrite_i, lsu_busy_i, perf_clr_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, wb_rd_addr_i;
  logic [1:0] ex_PCSrc_i;

  logic [1:0] rs1_sel [2];
  logic [1:0] rs2_sel [2];
  logic halt_if [2];
  logic halt_id [2];
  logic halt_ex [2];
  logic flush_id [2];
  logic flush_ex [2];
  logic redir [2];
  logic [3:0]  a_scnt, a_rcnt;
  logic [15:0] b_scnt, b_rcnt;

  int n_checks = 0;
  int n_errors = 0;

  int fl_left [2];
  int ld_left [2];
  int m_scnt  [2];
  int m_rcnt  [2];

  always #5 clk = ~clk;

  gs_pipeline_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .ex_valid_i(ex_valid_i), .ex_RegWrite_i(ex_RegWrite_i),
    .ex_MemRead_i(ex_MemRead_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_PCSrc_i(ex_PCSrc_i),
    .wb_valid_i(wb_valid_i), .wb_RegWrite_i(wb_RegWrite_i), .wb_rd_addr_i(wb_rd_addr_i),
    .lsu_busy_i(lsu_busy_i), .perf_clr_i(perf_clr_i),
    .rs1_forward_sel_o(rs1_sel[0]), .rs2_forward_sel_o(rs2_sel[0]),
    .halt_if_o(halt_if[0]), .halt_id_o(halt_id[0]), .halt_ex_o(halt_ex[0]),
    .flush_id_o(flush_id[0]), .flush_ex_o(flush_ex[0]), .pc_redirect_o(redir[0]),
    .stall_cnt_o(a_scnt), .redirect_cnt_o(a_rcnt));

  gs_pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(4), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .ex_valid_i(ex_valid_i), .ex_RegWrite_i(ex_RegWrite_i),
    .ex_MemRead_i(ex_MemRead_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_PCSrc_i(ex_PCSrc_i),
    .wb_valid_i(wb_valid_i), .wb_RegWrite_i(wb_RegWrite_i), .wb_rd_addr_i(wb_rd_addr_i),
    .lsu_busy_i(lsu_busy_i), .perf_clr_i(perf_clr_i),
    .rs1_forward_sel_o(rs1_sel[1]), .rs2_forward_sel_o(rs2_sel[1]),
    .halt_if_o(halt_if[1]), .halt_id_o(halt_id[1]), .halt_ex_o(halt_ex[1]),
    .flush_id_o(flush_id[1]), .flush_ex_o(flush_ex[1]), .pc_redirect_o(redir[1]),
    .stall_cnt_o(b_scnt), .redirect_cnt_o(b_rcnt));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int fwd(input logic [4:0] rs);
    if (ex_valid_i && ex_RegWrite_i && !ex_MemRead_i && ex_rd_addr_i != 0 && ex_rd_addr_i == rs)
      return 1;
    if (wb_valid_i && wb_RegWrite_i && wb_rd_addr_i != 0 && wb_rd_addr_i == rs)
      return 2;
    return 0;
  endfunction

  // Model: remaining flush cycles take precedence, then LSU wait, then remaining
  // load-stall cycles, then a fresh redirect, then a fresh load-use hazard.
  always @(negedge clk) begin
    int e1, e2, es, er, as, ar;
    bit eif, eid, eex, efid, efex, epc, lu, rd;
    for (int k = 0; k < 2; k++) begin
      e1 = 0; e2 = 0; eif = 0; eid = 0; eex = 0; efid = 0; efex = 0; epc = 0;
      es = 0; er = 0;
      as = (k == 0) ? int'(a_scnt) : int'(b_scnt);
      ar = (k == 0) ? int'(a_rcnt) : int'(b_rcnt);
      if (rst) begin
        fl_left[k] = 0; ld_left[k] = 0; m_scnt[k] = 0; m_rcnt[k] = 0;
      end else begin
        e1 = fwd(id_rs1_addr_i);
        e2 = fwd(id_rs2_addr_i);
        lu = id_valid_i && ex_valid_i && ex_MemRead_i && ex_rd_addr_i != 0 &&
             (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
        rd = ex_valid_i && ex_PCSrc_i != 0;
        es = m_scnt[k];
        er = m_rcnt[k];
        if (fl_left[k] > 0) begin
          efid = 1; efex = 1; fl_left[k]--;
        end else if (lsu_busy_i) begin
          eif = 1; eid = 1; eex = 1; ld_left[k] = 0;
        end else if (ld_left[k] > 0) begin
          eif = 1; eid = 1; efex = 1; ld_left[k]--;
        end else if (rd) begin
          epc = 1; efid = 1; efex = 1; fl_left[k] = FLC[k] - 1;
        end else if (lu) begin
          eif = 1; eid = 1; efex = 1; ld_left[k] = LSC[k] - 1;
        end
        if (perf_clr_i) begin
          m_scnt[k] = 0; m_rcnt[k] = 0;
        end else begin
          if (eid) m_scnt[k] = (m_scnt[k] < CMAX[k]) ? m_scnt[k] + 1 : CMAX[k];
          if (epc) m_rcnt[k] = (m_rcnt[k] < CMAX[k]) ? m_rcnt[k] + 1 : CMAX[k];
        end
      end
      chk($sformatf("rs1_sel[%0d]", k), int'(rs1_sel[k]), e1);
      chk($sformatf("rs2_sel[%0d]", k), int'(rs2_sel[k]), e2);
      chk($sformatf("halt_if[%0d]", k), int'(halt_if[k]), int'(eif));
      chk($sformatf("halt_id[%0d]", k), int'(halt_id[k]), int'(eid));
      chk($sformatf("halt_ex[%0d]", k), int'(halt_ex[k]), int'(eex));
      chk($sformatf("flush_id[%0d]", k), int'(flush_id[k]), int'(efid));
      chk($sformatf("flush_ex[%0d]", k), int'(flush_ex[k]), int'(efex));
      chk($sformatf("pc_redirect[%0d]", k), int'(redir[k]), int'(epc));
      chk($sformatf("stall_cnt[%0d]", k), as, es);
      chk($sformatf("redirect_cnt[%0d]", k), ar, er);
    end
  end

  task automatic idle();
    rst = 0; id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    ex_valid_i = 0; ex_RegWrite_i = 0; ex_MemRead_i = 0; ex_rd_addr_i = 0; ex_PCSrc_i = 0;
    wb_valid_i = 0; wb_RegWrite_i = 0; wb_rd_addr_i = 0; lsu_busy_i = 0; perf_clr_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // Reset with busy LSU and a forwarding hit present: everything must read 0.
    idle(); rst = 1; lsu_busy_i = 1; id_valid_i = 1; id_rs1_addr_i = 5;
    ex_valid_i = 1; ex_RegWrite_i = 1; ex_rd_addr_i = 5;
    #2; chk("lit rst halt_if", int'(halt_if[0]), 0); chk("lit rst rs1_sel", int'(rs1_sel[0]), 0);
    cycles(2);

    // Forwarding priority.
    idle(); id_valid_i = 1; id_rs1_addr_i = 5; id_rs2_addr_i = 0;
    ex_valid_i = 1; ex_RegWrite_i = 1; ex_rd_addr_i = 5;
    wb_valid_i = 1; wb_RegWrite_i = 1; wb_rd_addr_i = 5;
    #2; chk("lit fwd ex rs1", int'(rs1_sel[0]), 1); chk("lit fwd ex rs2", int'(rs2_sel[0]), 0);
    cyc();
    ex_valid_i = 0;
    #2; chk("lit fwd wb rs1", int'(rs1_sel[0]), 2);
    cyc();
    ex_valid_i = 1; ex_rd_addr_i = 0; wb_rd_addr_i = 0;
    #2; chk("lit fwd x0 rs1", int'(rs1_sel[0]), 0); chk("lit fwd x0 rs2", int'(rs2_sel[0]), 0);
    cyc();

    // Load-use hazard: EX load rd=7, ID rs2=7.
    idle(); id_valid_i = 1; id_rs2_addr_i = 7;
    ex_valid_i = 1; ex_RegWrite_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 7;
    #2; chk("lit lu halt_if", int'(halt_if[0]), 1); chk("lit lu flush_ex", int'(flush_ex[0]), 1);
    chk("lit lu halt_ex", int'(halt_ex[0]), 0); chk("lit lu rs2_sel", int'(rs2_sel[0]), 0);
    cyc(); idle();
    #2; chk("lit lu c1 halt_id a", int'(halt_id[0]), 1);
    cyc();
    #2; chk("lit lu c2 halt_id a", int'(halt_id[0]), 0); chk("lit lu c2 halt_id b", int'(halt_id[1]), 1);
    cyc();
    #2; chk("lit lu stall_cnt a", int'(a_scnt), 2); chk("lit lu stall_cnt b", int'(b_scnt), 3);
    cycles(2);

    // Redirect together with a load-use hazard: redirect wins, no stall.
    idle(); id_valid_i = 1; id_rs1_addr_i = 7;
    ex_valid_i = 1; ex_RegWrite_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 7; ex_PCSrc_i = 2'b01;
    #2; chk("lit rd pulse", int'(redir[0]), 1); chk("lit rd halt_id", int'(halt_id[0]), 0);
    chk("lit rd flush_id", int'(flush_id[0]), 1);
    cyc(); idle();
    #2; chk("lit rd c1 pulse", int'(redir[0]), 0); chk("lit rd c1 flush_ex", int'(flush_ex[0]), 1);
    cyc();
    #2; chk("lit rd c2 flush_id a", int'(flush_id[0]), 0); chk("lit rd c2 flush_id b", int'(flush_id[1]), 1);
    chk("lit rd redirect_cnt a", int'(a_rcnt), 1);
    cycles(4);

    // LSU busy for 3 cycles with a redirect pending in EX.
    idle(); lsu_busy_i = 1; ex_valid_i = 1; ex_PCSrc_i = 2'b10;
    #2; chk("lit mw c0 halt_ex", int'(halt_ex[0]), 1); chk("lit mw c0 pulse", int'(redir[0]), 0);
    cycles(2);
    #2; chk("lit mw c2 halt_if", int'(halt_if[0]), 1); chk("lit mw c2 pulse", int'(redir[0]), 0);
    cyc(); lsu_busy_i = 0;
    #2; chk("lit mw release pulse", int'(redir[0]), 1); chk("lit mw release halt_id", int'(halt_id[0]), 0);
    cyc(); idle();
    #2; chk("lit mw stall_cnt a", int'(a_scnt), 5);
    cycles(5);

    // Reset during the second flush cycle of u_b.
    idle(); ex_valid_i = 1; ex_PCSrc_i = 2'b01;
    #2; chk("lit rf pulse b", int'(redir[1]), 1);
    cyc(); idle(); rst = 1;
    #2; chk("lit rf rst flush_id b", int'(flush_id[1]), 0);
    cyc(); idle();
    #2; chk("lit rf post flush_ex b", int'(flush_ex[1]), 0); chk("lit rf post redirect_cnt b", int'(b_rcnt), 0);
    chk("lit rf post stall_cnt b", int'(b_scnt), 0);
    cyc();

    // Saturation and clear.
    idle(); lsu_busy_i = 1;
    cycles(20); idle();
    #2; chk("lit sat a", int'(a_scnt), 15); chk("lit sat b", int'(b_scnt), 20);
    cyc(); perf_clr_i = 1;
    cyc(); idle();
    #2; chk("lit clr a", int'(a_scnt), 0);
    cyc(); perf_clr_i = 1; lsu_busy_i = 1;
    cyc(); idle();
    #2; chk("lit clr over inc a", int'(a_scnt), 0);
    cyc();

    // Load stall on u_b preempted by a busy LSU: remaining count dropped.
    idle(); id_valid_i = 1; id_rs1_addr_i = 3; ex_valid_i = 1; ex_MemRead_i = 1; ex_rd_addr_i = 3;
    cyc(); idle(); lsu_busy_i = 1;
    #2; chk("lit pre halt_ex b", int'(halt_ex[1]), 1);
    cyc(); idle();
    #2; chk("lit pre flush_ex b", int'(flush_ex[1]), 0); chk("lit pre halt_id b", int'(halt_id[1]), 0);
    cycles(3);

    // Redirect held for 3 cycles: ignored while flushing, re-accepted after.
    idle(); ex_valid_i = 1; ex_PCSrc_i = 2'b11;
    cyc();
    #2; chk("lit hold c1 pulse b", int'(redir[1]), 0);
    cyc();
    #2; chk("lit hold c2 pulse a", int'(redir[0]), 1); chk("lit hold c2 pulse b", int'(redir[1]), 0);
    cyc(); idle();
    cycles(5);

    // Mixed pseudo-random traffic, checked by the model only.
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 60) == 0);
      id_valid_i    = 1'($urandom_range(0, 1));
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      ex_valid_i    = 1'($urandom_range(0, 1));
      ex_RegWrite_i = 1'($urandom_range(0, 1));
      ex_MemRead_i  = 1'($urandom_range(0, 1));
      ex_rd_addr_i  = 5'($urandom_range(0, 3));
      ex_PCSrc_i    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      wb_valid_i    = 1'($urandom_range(0, 1));
      wb_RegWrite_i = 1'($urandom_range(0, 1));
      wb_rd_addr_i  = 5'($urandom_range(0, 3));
      lsu_busy_i    = ($urandom_range(0, 3) == 0);
      perf_clr_i    = ($urandom_range(0, 40) == 0);
      cyc();
    end
    idle();
    cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gs_pipeline_ctrl.md
Name: gs_pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage GS core. It generates the rs1/rs2 forwarding selects consumed by the ID stage operand muxes, and the halt and flush controls for the IF, ID and EX stages. It covers load-use hazards, LSU wait and EX-resolved PC redirects. It also keeps saturating performance counters for stall cycles and redirects.

Parameters:
LOAD_STALL_CYCLES, 1, halt cycles per load-use hazard, including the detection cycle; legal range 1..7.
FLUSH_CYCLES, 1, cycles flush_id_o/flush_ex_o stay high per redirect, including the redirect cycle; legal range 1..7.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  5  ID source register 1
id_rs2_addr_i  in  5  ID source register 2
ex_valid_i  in  1  EX holds a valid instruction
ex_RegWrite_i  in  1  EX instruction writes rd
ex_MemRead_i  in  1  EX instruction is a load
ex_rd_addr_i  in  5  EX destination
ex_PCSrc_i  in  2  EX PC source; non-zero means taken branch/jump
wb_valid_i  in  1  WB holds a valid instruction
wb_RegWrite_i  in  1  WB instruction writes rd
wb_rd_addr_i  in  5  WB destination
lsu_busy_i  in  1  LSU has not completed its access
perf_clr_i  in  1  clear performance counters
rs1_forward_sel_o  out  2  0=REG_NO_FORWARD, 1=REG_EX_FORWARD, 2=REG_WB_FORWARD
rs2_forward_sel_o  out  2  same encoding for rs2
halt_if_o  out  1  hold IF
halt_id_o  out  1  hold ID
halt_ex_o  out  1  hold EX
flush_id_o  out  1  squash ID
flush_ex_o  out  1  insert bubble into EX
pc_redirect_o  out  1  one-cycle pulse: IF loads redirected PC
stall_cnt_o  out  CNT_W  cycles with halt_id_o=1, saturating
redirect_cnt_o  out  CNT_W  accepted redirects, saturating

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- While rst=1: all outputs read 0, FSM goes to RUN, stall counter cnt goes to 0, both perf counters go to 0. A reset mid-stall or mid-flush takes effect at the next edge; no residual halt or flush follows.
- Forwarding (combinational, every cycle):
  - EX hit: ex_valid_i & ex_RegWrite_i & !ex_MemRead_i & ex_rd_addr_i!=0 & ex_rd_addr_i==rsN.
  - WB hit: wb_valid_i & wb_RegWrite_i & wb_rd_addr_i!=0 & wb_rd_addr_i==rsN.
  - Select is 1 on an EX hit, else 2 on a WB hit, else 0. EX has priority; x0 never forwards.
- Hazard terms:
  - LU (load-use) = id_valid_i & ex_valid_i & ex_MemRead_i & ex_rd_addr_i!=0 & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
  - RD (redirect) = ex_valid_i & ex_PCSrc_i!=0.
- FSM states are RUN, LSTALL, MWAIT and FLUSH. Outputs are Mealy, so a response appears in the same cycle as its cause.
- RUN, evaluated in priority order:
  1. lsu_busy_i: halt_if_o=halt_id_o=halt_ex_o=1; go to MWAIT.
  2. else RD: pc_redirect_o=1, flush_id_o=flush_ex_o=1, redirect_cnt_o+1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  3. else LU: halt_if_o=halt_id_o=1, flush_ex_o=1 (bubble). If LOAD_STALL_CYCLES>1, go to LSTALL with cnt=LOAD_STALL_CYCLES-1.
  4. else all controls are 0.
- LSTALL: same outputs as a RUN LU cycle. cnt decrements each cycle; return to RUN when cnt reaches 1. lsu_busy_i preempts: go to MWAIT and drop the remaining count.
- MWAIT: all three halts are 1 and no flush is driven. On the first cycle lsu_busy_i=0, return to RUN and re-evaluate the RUN rules in that same cycle. A redirect pending in EX is therefore accepted in the release cycle, not lost.
- FLUSH: flush_id_o=flush_ex_o=1 and pc_redirect_o=0. cnt decrements; return to RUN when cnt reaches 1. A new RD in FLUSH is ignored; EX is being flushed, so it cannot present a valid redirect.
- Simultaneous events:
  - RD and LU together: RD wins. No stall occurs and the ID instruction is squashed.
  - lsu_busy_i and RD together: the halt wins and the redirect is deferred.
- Counters:
  - stall_cnt_o increments on every cycle with halt_id_o=1 and saturates at all-ones.
  - redirect_cnt_o counts only pc_redirect_o pulses and saturates at all-ones.
  - perf_clr_i zeroes both counters and overrides an increment in the same cycle.

Test Plan:
- Forward priority: ex rd=5 (RegWrite, no load) and wb rd=5, ID rs1=5, rs2=0 -> rs1_forward_sel_o=1, rs2_forward_sel_o=0. Drop ex_valid_i -> rs1_forward_sel_o=2. Set rd=0 -> both selects 0.
- Load-use, LOAD_STALL_CYCLES=2: EX load rd=7, ID rs2=7 -> halt_if_o/halt_id_o/flush_ex_o=1 for exactly 2 cycles; stall_cnt_o=2.
- Redirect with simultaneous LU, FLUSH_CYCLES=2: ex_PCSrc_i=2'b01 with LU true -> pc_redirect_o pulses 1 cycle, flush_id_o/flush_ex_o high 2 cycles, no halt, redirect_cnt_o=1.
- LSU wait with pending redirect: lsu_busy_i high 3 cycles while RD is true -> 3 cycles with all halts=1 and no redirect; pc_redirect_o pulses in the 4th cycle.
- Reset mid-flush (FLUSH_CYCLES=4): assert rst in the 2nd flush cycle -> next cycle all outputs are 0, state is RUN and counters are 0.
- Saturation, CNT_W=4: hold lsu_busy_i for 20 cycles -> stall_cnt_o holds at 15. perf_clr_i -> 0.
